// File: rtl/isr_shifter_pkg.sv
// Shared PIO definitions for the input shift register: width, shift
// direction encodings, FSM states and the 5-bit "0 means 32" decode.
package isr_shifter_pkg;
   localparam int   WIDTH = 32;
   localparam int   CNT_W = 6;
   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   typedef enum logic {ST_IDLE, ST_PUSH_WAIT} isr_state_e;

   function automatic logic [CNT_W-1:0] decode_n32(input logic [4:0] v);
      return (v == 5'd0) ? 6'd32 : {1'b0, v};
   endfunction
endpackage

// File: rtl/isr_shifter_if.sv
// ISR -> RX FIFO push handshake; the shifter is the master.
interface isr_shifter_if;
   import isr_shifter_pkg::*;
   logic             push_valid;
   logic [WIDTH-1:0] push_data;
   logic             push_ready;

   modport master (output push_valid, output push_data, input push_ready);
   modport slave  (input push_valid, input push_data, output push_ready);
endinterface

// File: rtl/isr_shifter_merge.sv
// Combinational merge of n new bits into the ISR word, either direction.
module isr_merge
   import isr_shifter_pkg::*;
(
   input  logic [WIDTH-1:0] isr_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic [CNT_W-1:0] n_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] word_o
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] din_m;

   // n=32 makes the shifts by 32 vanish, so the whole word becomes din
   always_comb begin
      din_m = din_i & ((ONE << n_i) - ONE);
      if (dir_i == SHIFT_RIGHT) begin
         word_o = (isr_i >> n_i) | (din_m << (7'(WIDTH) - {1'b0, n_i}));
      end else begin
         word_o = (isr_i << n_i) | din_m;
      end
   end
endmodule

// File: rtl/isr_shifter.sv
// PIO input shift register: IN shifting, shift count, and PUSH/autopush
// hand-off to the RX FIFO with stall while a blocking push waits.
module isr_shifter
   import isr_shifter_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               penable,
   input  logic               shift_en,
   input  logic [WIDTH-1:0]   din,
   input  logic [4:0]         bit_count,
   input  logic               dir,
   input  logic               set,
   input  logic [WIDTH-1:0]   set_val,
   input  logic               push_req,
   input  logic               push_block,
   input  logic               autopush,
   input  logic [4:0]         threshold,
   isr_shifter_if.master      push,
   output logic               stall,
   output logic [WIDTH-1:0]   dout,
   output logic [CNT_W-1:0]   shift_count
);
   isr_state_e       state_q, state_d;
   logic [WIDTH-1:0] isr_q, isr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] merged;
   logic [CNT_W-1:0] n, thr, cnt_sat;
   logic [CNT_W:0]   sum;
   logic             valid_c, stall_c, take;

   assign n       = decode_n32(bit_count);
   assign thr     = decode_n32(threshold);
   assign sum     = {1'b0, cnt_q} + {1'b0, n};
   assign cnt_sat = (sum > 7'd32) ? 6'd32 : sum[CNT_W-1:0];
   assign take    = push.push_ready & penable;

   isr_merge u_merge (
      .isr_i  (isr_q),
      .din_i  (din),
      .n_i    (n),
      .dir_i  (dir),
      .word_o (merged)
   );

   always_comb begin
      state_d = state_q;
      isr_d   = isr_q;
      cnt_d   = cnt_q;
      valid_c = 1'b0;
      stall_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (penable) begin
               if (set) begin
                  isr_d = set_val;
                  cnt_d = '0;
               end else if (push_req) begin
                  valid_c = 1'b1;
                  if (!push.push_ready && push_block) begin
                     state_d = ST_PUSH_WAIT;
                     stall_c = 1'b1;
                  end else begin
                     // taken by the FIFO, or dropped by a non-blocking push
                     isr_d = '0;
                     cnt_d = '0;
                  end
               end else if (shift_en) begin
                  isr_d = merged;
                  cnt_d = cnt_sat;
                  if (autopush && (cnt_sat >= thr)) state_d = ST_PUSH_WAIT;
               end
            end
         end
         ST_PUSH_WAIT: begin
            valid_c = 1'b1;
            stall_c = !take;
            if (take) begin
               isr_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         isr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         isr_q   <= isr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign push.push_valid = valid_c;
   assign push.push_data  = isr_q;
   assign stall           = stall_c;
   assign dout            = isr_q;
   assign shift_count     = cnt_q;
endmodule

// File: tb/tb_isr_shifter.sv
// Bench for isr_shifter: directed scenarios plus randomized traffic against
// an arithmetic model of the ISR, shift count and push state.
module tb_isr_shifter;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        penable, shift_en, dir, set, push_req, push_block, autopush;
   logic [31:0] din, set_val;
   logic [4:0]  bit_count, threshold;
   logic        stall;
   logic [31:0] dout;
   logic [5:0]  shift_count;
   int          checks = 0;
   int          failures = 0;
   int          xfers = 0;

   isr_shifter_if bus();

   isr_shifter dut (
      .clk         (clk),
      .resetn      (resetn),
      .penable     (penable),
      .shift_en    (shift_en),
      .din         (din),
      .bit_count   (bit_count),
      .dir         (dir),
      .set         (set),
      .set_val     (set_val),
      .push_req    (push_req),
      .push_block  (push_block),
      .autopush    (autopush),
      .threshold   (threshold),
      .push        (bus),
      .stall       (stall),
      .dout        (dout),
      .shift_count (shift_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (resetn && bus.push_valid && bus.push_ready && penable) xfers <= xfers + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      penable = 1'b1; shift_en = 1'b0; dir = 1'b0; set = 1'b0;
      push_req = 1'b0; push_block = 1'b0; autopush = 1'b0;
      din = '0; set_val = '0; bit_count = '0; threshold = '0;
      bus.push_ready = 1'b0;
   endtask

   task automatic do_reset;
      clear_inputs();
      resetn = 1'b0;
      #3;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
      checks++; if (shift_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", shift_count); end
      dir = 1'b1; bit_count = 5'd8; din = 32'hA5; shift_en = 1'b1;
      tick();
      shift_en = 1'b0; push_req = 1'b1; push_block = 1'b1;
      tick();
      clear_inputs();
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (dout !== 32'h0) begin failures++; $display("FAIL async_reset_dout got=%h exp=0", dout); end
      checks++; if (shift_count !== 6'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", shift_count); end
      checks++; if (bus.push_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", bus.push_valid); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL async_reset_stall got=%b exp=0", stall); end
      #1;
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_shift_right;
      do_reset();
      dir = 1'b1; bit_count = 5'd8; din = 32'hA5; shift_en = 1'b1;
      repeat (4) tick();
      shift_en = 1'b0;
      checks++; if (dout !== 32'hA5A5A5A5) begin failures++; $display("FAIL right8_dout got=%h exp=a5a5a5a5", dout); end
      checks++; if (shift_count !== 6'd32) begin failures++; $display("FAIL right8_count got=%0d exp=32", shift_count); end
      din = 32'h3C; shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      checks++; if (dout !== 32'h3CA5A5A5) begin failures++; $display("FAIL sat_dout got=%h exp=3ca5a5a5", dout); end
      checks++; if (shift_count !== 6'd32) begin failures++; $display("FAIL sat_count got=%0d exp=32", shift_count); end
      do_reset();
      dir = 1'b1; bit_count = 5'd4; din = 32'hF; shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      checks++; if (dout !== 32'hF0000000) begin failures++; $display("FAIL right4_dout got=%h exp=f0000000", dout); end
      checks++; if (shift_count !== 6'd4) begin failures++; $display("FAIL right4_count got=%0d exp=4", shift_count); end
   endtask

   task automatic test_autopush_left;
      int x0;
      do_reset();
      x0 = xfers;
      dir = 1'b0; autopush = 1'b1; threshold = 5'd16; bus.push_ready = 1'b1;
      bit_count = 5'd8; din = 32'h12; shift_en = 1'b1;
      tick();
      checks++; if (bus.push_valid !== 1'b0) begin failures++; $display("FAIL ap_early_valid got=%b exp=0", bus.push_valid); end
      din = 32'h34;
      tick();
      shift_en = 1'b0;
      checks++; if (bus.push_valid !== 1'b1) begin failures++; $display("FAIL ap_valid got=%b exp=1", bus.push_valid); end
      checks++; if (bus.push_data !== 32'h00001234) begin failures++; $display("FAIL ap_data got=%h exp=00001234", bus.push_data); end
      tick();
      checks++; if (xfers !== x0 + 1) begin failures++; $display("FAIL ap_xfers got=%0d exp=%0d", xfers, x0 + 1); end
      checks++; if (dout !== 32'h0 || shift_count !== 6'd0) begin
         failures++; $display("FAIL ap_clear got=%h/%0d exp=0/0", dout, shift_count); end
      threshold = 5'd0; bit_count = 5'd16; din = 32'hBEEF; shift_en = 1'b1;
      tick();
      checks++; if (bus.push_valid !== 1'b0) begin failures++; $display("FAIL thr32_early got=%b exp=0", bus.push_valid); end
      din = 32'hCAFE;
      tick();
      shift_en = 1'b0;
      checks++; if (bus.push_valid !== 1'b1 || bus.push_data !== 32'hBEEFCAFE) begin
         failures++; $display("FAIL thr32_push got=%b/%h exp=1/beefcafe", bus.push_valid, bus.push_data); end
      tick();
   endtask

   task automatic test_block_push;
      int x0;
      do_reset();
      dir = 1'b0; bit_count = 5'd0; din = 32'hCAFEF00D; shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      x0 = xfers;
      push_req = 1'b1; push_block = 1'b1; bus.push_ready = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL blk_issue_stall got=%b exp=1", stall); end
      tick();
      shift_en = 1'b1; din = 32'h11111111; set = 1'b1; set_val = 32'h0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (stall !== 1'b1 || bus.push_valid !== 1'b1 || bus.push_data !== 32'hCAFEF00D) begin
            failures++; $display("FAIL blk_wait%0d got=%b/%b/%h exp=1/1/cafef00d", c, stall, bus.push_valid, bus.push_data); end
         tick();
      end
      bus.push_ready = 1'b1;
      #1;
      checks++; if (stall !== 1'b0 || bus.push_valid !== 1'b1) begin
         failures++; $display("FAIL blk_accept got=%b/%b exp=0/1", stall, bus.push_valid); end
      tick();
      clear_inputs();
      #1;
      checks++; if (xfers !== x0 + 1) begin failures++; $display("FAIL blk_xfers got=%0d exp=%0d", xfers, x0 + 1); end
      checks++; if (dout !== 32'h0 || shift_count !== 6'd0 || stall !== 1'b0) begin
         failures++; $display("FAIL blk_after got=%h/%0d/%b exp=0/0/0", dout, shift_count, stall); end
   endtask

   task automatic test_nonblock_push;
      int x0;
      do_reset();
      dir = 1'b1; bit_count = 5'd12; din = 32'hABC; shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      x0 = xfers;
      push_req = 1'b1; push_block = 1'b0; bus.push_ready = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nb_stall got=%b exp=0", stall); end
      tick();
      push_req = 1'b0;
      #1;
      checks++; if (xfers !== x0) begin failures++; $display("FAIL nb_xfers got=%0d exp=%0d", xfers, x0); end
      checks++; if (dout !== 32'h0 || shift_count !== 6'd0 || bus.push_valid !== 1'b0) begin
         failures++; $display("FAIL nb_clear got=%h/%0d/%b exp=0/0/0", dout, shift_count, bus.push_valid); end
   endtask

   task automatic test_set_penable;
      int x0;
      do_reset();
      dir = 1'b0; bit_count = 5'd4; din = 32'h7; shift_en = 1'b1;
      tick();
      set = 1'b1; set_val = 32'hDEADBEEF; din = $urandom; autopush = 1'b1; threshold = 5'd1;
      tick();
      set = 1'b0;
      checks++; if (dout !== 32'hDEADBEEF || shift_count !== 6'd0 || bus.push_valid !== 1'b0) begin
         failures++; $display("FAIL set_win got=%h/%0d/%b exp=deadbeef/0/0", dout, shift_count, bus.push_valid); end
      penable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (dout !== 32'hDEADBEEF || shift_count !== 6'd0) begin
            failures++; $display("FAIL pen_hold%0d got=%h/%0d exp=deadbeef/0", c, dout, shift_count); end
      end
      penable = 1'b1; shift_en = 1'b0; autopush = 1'b0;
      push_req = 1'b1; push_block = 1'b1;
      tick();
      push_req = 1'b0; penable = 1'b0; bus.push_ready = 1'b1;
      x0 = xfers;
      repeat (2) tick();
      checks++; if (xfers !== x0 || bus.push_valid !== 1'b1 || stall !== 1'b1) begin
         failures++; $display("FAIL pen_wait got=%0d/%b/%b exp=%0d/1/1", xfers, bus.push_valid, stall, x0); end
      penable = 1'b1;
      tick();
      checks++; if (xfers !== x0 + 1 || dout !== 32'h0) begin
         failures++; $display("FAIL pen_release got=%0d/%h exp=%0d/0", xfers, dout, x0 + 1); end
   endtask

   task automatic test_random;
      logic        mw, ev, es;
      logic [31:0] mi, ed;
      int          mc, n, thr;
      longint      dm, p2n;
      do_reset();
      mw = 1'b0; mi = '0; mc = 0;
      for (int i = 0; i < 400; i++) begin
         penable = ($urandom_range(0, 7) != 0);
         set = ($urandom_range(0, 15) == 0);
         push_req = ($urandom_range(0, 9) == 0);
         shift_en = $urandom_range(0, 1);
         din = $urandom; set_val = $urandom;
         bit_count = 5'($urandom_range(0, 31));
         threshold = 5'($urandom_range(0, 31));
         dir = $urandom_range(0, 1);
         autopush = $urandom_range(0, 1);
         push_block = $urandom_range(0, 1);
         bus.push_ready = $urandom_range(0, 1);
         #1;
         n = (bit_count == 0) ? 32 : int'(bit_count);
         thr = (threshold == 0) ? 32 : int'(threshold);
         ev = 1'b0; es = 1'b0; ed = mi;
         if (mw) begin
            ev = 1'b1;
            es = !(bus.push_ready && penable);
            if (bus.push_ready && penable) begin mi = '0; mc = 0; mw = 1'b0; end
         end else if (penable) begin
            if (set) begin
               mi = set_val; mc = 0;
            end else if (push_req) begin
               ev = 1'b1;
               if (!bus.push_ready && push_block) begin mw = 1'b1; es = 1'b1; end
               else begin mi = '0; mc = 0; end
            end else if (shift_en) begin
               p2n = longint'(1) << n;
               dm = longint'(din) % p2n;
               if (dir) mi = 32'(longint'(mi) / p2n + dm * (longint'(1) << (32 - n)));
               else     mi = 32'((longint'(mi) * p2n + dm) % (longint'(1) << 32));
               mc = (mc + n > 32) ? 32 : mc + n;
               if (autopush && mc >= thr) mw = 1'b1;
            end
         end
         checks++; if (bus.push_valid !== ev) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.push_valid, ev); end
         checks++; if (stall !== es) begin failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall, es); end
         if (ev) begin
            checks++; if (bus.push_data !== ed) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, bus.push_data, ed); end
         end
         tick();
         checks++; if (dout !== mi) begin failures++; $display("FAIL rnd_dout[%0d] got=%h exp=%h", i, dout, mi); end
         checks++; if (shift_count !== 6'(mc)) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, shift_count, mc); end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_shift_right();
      test_autopush_left();
      test_block_push();
      test_nonblock_push();
      test_set_penable();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
